// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: multi-button synchroniser, shared-tick debouncer and
// press/release/long-press event queue with a valid/ready drain port.
// Optional feature macro: BTN_LONG_PRESS_EN builds the long-press counters
// and the kind 2'b10 event; without it evt_kind_o[1] is tied low.

// Per-button datapath: synchroniser, debounce, optional long-press counter
// and the single-entry pending-event slot.
module btn_event_lane #(
    parameter int STABLE_TICKS = 1000,
    parameter int LONG_TICKS   = 250000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       btn_i,
    input  logic       tick_i,
    input  logic       grant_i,
    output logic       level_o,
    output logic       pend_vld_o,
    output logic [1:0] pend_kind_o,
    output logic       drop_o
);
    localparam int DBW = $clog2(STABLE_TICKS + 1);

    logic [1:0]     sync_q;
    logic           level_q, level_d;
    logic [DBW-1:0] db_q, db_d;
    logic           flip;
    logic           long_hit;
    logic           raise;
    logic [1:0]     raise_kind;
    logic           pend_vld_q, pend_vld_d;
    logic [1:0]     pend_kind_q, pend_kind_d;

    // Two-flop synchroniser; sync_q[1] is the level seen by the debouncer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= {sync_q[0], btn_i};
    end

    // Debounce: any cycle where sync matches level restarts the count,
    // so a bounce between ticks still discards progress
    always_comb begin
        db_d    = db_q;
        level_d = level_q;
        flip    = 1'b0;
        if (sync_q[1] == level_q) begin
            db_d = '0;
        end else if (tick_i) begin
            if (db_q == DBW'(STABLE_TICKS - 1)) begin
                flip    = 1'b1;
                level_d = ~level_q;
                db_d    = '0;
            end else begin
                db_d = db_q + 1'b1;
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= 1'b0;
            db_q    <= '0;
        end else begin
            level_q <= level_d;
            db_q    <= db_d;
        end
    end

`ifdef BTN_LONG_PRESS_EN
    localparam int LPW = $clog2(LONG_TICKS + 1);
    logic [LPW-1:0] lp_q, lp_d;

    // Long-press: count ticks while held, fire once on reaching the limit,
    // then saturate so a single hold yields at most one long-press
    always_comb begin
        lp_d     = lp_q;
        long_hit = 1'b0;
        if (!level_q) begin
            lp_d = '0;
        end else if (tick_i && (lp_q != LPW'(LONG_TICKS))) begin
            lp_d = lp_q + 1'b1;
            if (lp_q == LPW'(LONG_TICKS - 1)) long_hit = 1'b1;
        end
    end

    // Long-press counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lp_q <= '0;
        else         lp_q <= lp_d;
    end
`else
    // Long-press not built; the parameter is accepted but has no effect
    localparam int unused_long_ticks = LONG_TICKS;
    assign long_hit = 1'b0;
`endif

    // Event source: a release landing on the same tick as the long-press
    // limit wins, since the button is no longer held
    always_comb begin
        raise      = 1'b0;
        raise_kind = 2'b00;
        if (flip) begin
            raise      = 1'b1;
            raise_kind = level_q ? 2'b01 : 2'b00;
        end else if (long_hit) begin
            raise      = 1'b1;
            raise_kind = 2'b10;
        end
    end

    // Pending slot: grant clears it; a new event into an occupied slot
    // (even one being granted this cycle) is dropped and flagged
    always_comb begin
        pend_vld_d  = pend_vld_q;
        pend_kind_d = pend_kind_q;
        drop_o      = 1'b0;
        if (grant_i) pend_vld_d = 1'b0;
        if (raise) begin
            if (pend_vld_q) begin
                drop_o = 1'b1;
            end else begin
                pend_vld_d  = 1'b1;
                pend_kind_d = raise_kind;
            end
        end
    end

    // Pending slot registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_vld_q  <= 1'b0;
            pend_kind_q <= 2'b00;
        end else begin
            pend_vld_q  <= pend_vld_d;
            pend_kind_q <= pend_kind_d;
        end
    end

    assign level_o     = level_q;
    assign pend_vld_o  = pend_vld_q;
    assign pend_kind_o = pend_kind_q;
endmodule

module btn_event_ctrl #(
    parameter int NUM_BTN      = 4,
    parameter int TICK_DIV     = 4000,
    parameter int STABLE_TICKS = 1000,
    parameter int LONG_TICKS   = 250000,
    parameter int EVT_DEPTH    = 4,
    localparam int IDW = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic [NUM_BTN-1:0] btn_level_o,
    output logic               evt_valid_o,
    input  logic               evt_ready_i,
    output logic [IDW-1:0]     evt_id_o,
    output logic [1:0]         evt_kind_o,
    output logic               evt_overflow_o,
    input  logic               clr_overflow_i
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int AW = $clog2(EVT_DEPTH);
    localparam int CW = $clog2(EVT_DEPTH + 1);
    localparam int EW = IDW + 2;

    logic [PW-1:0]                 presc_q, presc_d;
    logic                          tick;
    logic [NUM_BTN-1:0]            pend_vld;
    logic [NUM_BTN-1:0][1:0]       pend_kind;
    logic [NUM_BTN-1:0]            drop;
    logic [NUM_BTN-1:0]            sel;
    logic [NUM_BTN-1:0]            grant;
    logic                          arb_vld;
    logic [IDW-1:0]                arb_id;
    logic [1:0]                    arb_kind;
    logic                          push, pop, full;
    logic [EVT_DEPTH-1:0][EW-1:0]  mem_q;
    logic [AW-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic                          ovf_q, ovf_d;
    logic [EW-1:0]                 head;

    // Shared prescaler: one-cycle tick every TICK_DIV clocks
    assign tick = (presc_q == PW'(TICK_DIV - 1));
    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // Prescaler register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) presc_q <= '0;
        else         presc_q <= presc_d;
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_lane
        btn_event_lane #(
            .STABLE_TICKS (STABLE_TICKS),
            .LONG_TICKS   (LONG_TICKS)
        ) u_lane (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .btn_i       (btn_i[g]),
            .tick_i      (tick),
            .grant_i     (grant[g]),
            .level_o     (btn_level_o[g]),
            .pend_vld_o  (pend_vld[g]),
            .pend_kind_o (pend_kind[g]),
            .drop_o      (drop[g])
        );
    end

    assign full = (cnt_q == CW'(EVT_DEPTH));
    assign pop  = (cnt_q != '0) && evt_ready_i;

    // Fixed-priority arbiter: lowest-index pending slot moves to the FIFO;
    // a full FIFO still accepts when the head leaves in the same cycle
    always_comb begin
        sel      = '0;
        arb_vld  = 1'b0;
        arb_id   = '0;
        arb_kind = 2'b00;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (pend_vld[i] && !arb_vld) begin
                arb_vld  = 1'b1;
                arb_id   = IDW'(i);
                arb_kind = pend_kind[i];
                sel[i]   = 1'b1;
            end
        end
        push  = arb_vld && (!full || pop);
        grant = push ? sel : '0;
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO control registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // FIFO storage; contents only matter behind a valid count
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {arb_id, arb_kind};
    end

    // Sticky overflow: a drop in the same cycle as a clear keeps it set
    always_comb begin
        ovf_d = ovf_q;
        if (clr_overflow_i) ovf_d = 1'b0;
        if (|drop)          ovf_d = 1'b1;
    end

    // Overflow flag register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ovf_q <= 1'b0;
        else         ovf_q <= ovf_d;
    end

    assign head           = mem_q[rd_ptr_q];
    assign evt_valid_o    = (cnt_q != '0);
    assign evt_id_o       = head[EW-1:2];
    assign evt_overflow_o = ovf_q;
`ifdef BTN_LONG_PRESS_EN
    assign evt_kind_o     = head[1:0];
`else
    assign evt_kind_o     = head[1:0] & 2'b01;
`endif
endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl with small parameters
// (NUM_BTN=2, TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=8, EVT_DEPTH=2).
module tb_btn_event_ctrl;
    localparam int NB = 2;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam int LT = 8;
    localparam int ED = 2;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic [1:0] btn = 2'b00;
    logic       ready = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] level;
    logic       valid;
    logic [0:0] id;
    logic [1:0] kind;
    logic       ovf;

    int checks = 0;
    int errors = 0;
    int cyc;

    btn_event_ctrl #(
        .NUM_BTN(NB), .TICK_DIV(TD), .STABLE_TICKS(ST),
        .LONG_TICKS(LT), .EVT_DEPTH(ED)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .btn_i          (btn),
        .btn_level_o    (level),
        .evt_valid_o    (valid),
        .evt_ready_i    (ready),
        .evt_id_o       (id),
        .evt_kind_o     (kind),
        .evt_overflow_o (ovf),
        .clr_overflow_i (clr)
    );

    always #5 clk = ~clk;

    // Edges since reset release: tick edges are the multiples of TD
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    typedef struct {
        logic [1:0] btn;
        logic       rdy;
        logic       clr;
        int         hold;
        logic [1:0] lvl;
        logic       vld;
        logic       id;
        logic [1:0] kind;
        logic       ovf;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Edge at which a level change driven after edge a is accepted
    function automatic int exp_flip(input int a);
        int t;
        t = a + 3;
        while (t % TD != 0) t++;
        return t + (ST - 1) * TD;
    endfunction

    task automatic wait_level(input int idx, input logic val, input int maxc, output int at);
        at = -1;
        for (int i = 0; i < maxc; i++) begin
            step(1);
            if (level[idx] === val) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic pop_expect(input string name, input int eid, input int ekind,
                              input int maxc, output int at);
        at = -1;
        for (int i = 0; i < maxc; i++) begin
            if (valid === 1'b1) begin
                at = cyc;
                break;
            end
            step(1);
        end
        chk({name, " arrived"}, int'(at != -1), 1);
        chk({name, " id"}, int'(id), eid);
        chk({name, " kind"}, int'(kind), ekind);
        ready = 1'b1;
        step(1);
        ready = 1'b0;
    endtask

    initial begin
        int a, at, f;
        bit bad;

        tbl[0] = '{2'b01, 1'b0, 1'b0, 20, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0};
        tbl[1] = '{2'b00, 1'b0, 1'b0, 20, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0};
        tbl[2] = '{2'b10, 1'b0, 1'b0, 20, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0};
        tbl[3] = '{2'b00, 1'b0, 1'b0, 20, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1};
        tbl[4] = '{2'b00, 1'b0, 1'b1, 1,  2'b00, 1'b1, 1'b0, 2'b00, 1'b0};
        tbl[5] = '{2'b00, 1'b1, 1'b0, 1,  2'b00, 1'b1, 1'b0, 2'b01, 1'b0};
        tbl[6] = '{2'b00, 1'b1, 1'b0, 1,  2'b00, 1'b1, 1'b1, 2'b00, 1'b0};
        tbl[7] = '{2'b00, 1'b1, 1'b0, 1,  2'b00, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[8] = '{2'b00, 1'b0, 1'b0, 4,  2'b00, 1'b0, 1'b0, 2'b00, 1'b0};

        // Reset state
        #22;
        chk("rst level", int'(level), 0);
        chk("rst valid", int'(valid), 0);
        chk("rst ovf", int'(ovf), 0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        step(1);
        chk("post-rst valid", int'(valid), 0);

        // 1: clean press on button 0
        a = cyc; btn[0] = 1'b1;
        wait_level(0, 1'b1, 30, at);
        chk("s1 press flip edge", at, exp_flip(a));
        chk("s1 valid at flip", int'(valid), 0);
        step(1);
        chk("s1 valid next", int'(valid), 1);
        chk("s1 id", int'(id), 0);
        chk("s1 kind", int'(kind), 0);
        ready = 1'b1; step(1); ready = 1'b0;
        chk("s1 empty after pop", int'(valid), 0);
        a = cyc; btn[0] = 1'b0;
        wait_level(0, 1'b0, 30, at);
        chk("s1 release flip edge", at, exp_flip(a));
        pop_expect("s1 release", 0, 1, 5, at);

        // 2: bouncing button 1, then settle high
        bad = 1'b0;
        for (int h = 0; h < 12; h++) begin
            btn[1] = (h % 2 == 0);
            for (int k = 0; k < 5; k++) begin
                step(1);
                if (level !== 2'b00 || valid !== 1'b0) bad = 1'b1;
            end
        end
        chk("s2 quiet while bouncing", int'(bad), 0);
        a = cyc; btn[1] = 1'b1;
        wait_level(1, 1'b1, 30, at);
        chk("s2 press flip edge", at, exp_flip(a));
        pop_expect("s2 press", 1, 0, 5, at);
        step(8);
        chk("s2 single event", int'(valid), 0);
        a = cyc; btn[1] = 1'b0;
        wait_level(1, 1'b0, 30, at);
        pop_expect("s2 release", 1, 1, 5, at);

        // 3: simultaneous presses enter on consecutive cycles
        a = cyc; btn = 2'b11;
        wait_level(0, 1'b1, 30, at);
        chk("s3 flip edge", at, exp_flip(a));
        chk("s3 both levels", int'(level), 3);
        step(1);
        chk("s3 first valid", int'(valid), 1);
        chk("s3 first id", int'(id), 0);
        chk("s3 first kind", int'(kind), 0);
        ready = 1'b1; step(1);
        chk("s3 second valid", int'(valid), 1);
        chk("s3 second id", int'(id), 1);
        chk("s3 second kind", int'(kind), 0);
        step(1); ready = 1'b0;
        chk("s3 drained", int'(valid), 0);
        btn = 2'b00;
        wait_level(0, 1'b0, 30, at);
        pop_expect("s3 rel0", 0, 1, 5, at);
        pop_expect("s3 rel1", 1, 1, 5, at);

        // 4: long hold on button 0
        a = cyc; btn[0] = 1'b1;
        wait_level(0, 1'b1, 30, f);
        chk("s4 press flip edge", f, exp_flip(a));
        pop_expect("s4 press", 0, 0, 5, at);
`ifdef BTN_LONG_PRESS_EN
        pop_expect("s4 long", 0, 2, 50, at);
        chk("s4 long edge", at, f + 33);
`endif
        step(60);
        chk("s4 nothing further while held", int'(valid), 0);
        btn[0] = 1'b0;
        wait_level(0, 1'b0, 30, at);
        pop_expect("s4 release", 0, 1, 5, at);
        step(2);
        chk("s4 drained", int'(valid), 0);

        // 5: FIFO full, pending wait and overflow (table)
        for (int i = 0; i < 9; i++) begin
            btn = tbl[i].btn; ready = tbl[i].rdy; clr = tbl[i].clr;
            step(tbl[i].hold);
            chk($sformatf("t%0d level", i), int'(level), int'(tbl[i].lvl));
            chk($sformatf("t%0d valid", i), int'(valid), int'(tbl[i].vld));
            chk($sformatf("t%0d ovf", i), int'(ovf), int'(tbl[i].ovf));
            if (tbl[i].vld) begin
                chk($sformatf("t%0d id", i), int'(id), int'(tbl[i].id));
                chk($sformatf("t%0d kind", i), int'(kind), int'(tbl[i].kind));
            end
        end
        ready = 1'b0; clr = 1'b0;

        // 6: async reset with a full FIFO and a held button
        btn[1] = 1'b1;
        wait_level(1, 1'b1, 30, at);
        btn[1] = 1'b0;
        wait_level(1, 1'b0, 30, at);
        btn[0] = 1'b1;
        wait_level(0, 1'b1, 30, at);
        chk("s6 pre-reset valid", int'(valid), 1);
        chk("s6 pre-reset level", int'(level), 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("s6 async level", int'(level), 0);
        chk("s6 async valid", int'(valid), 0);
        chk("s6 async ovf", int'(ovf), 0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        chk("s6 queue cleared", int'(valid), 0);
        wait_level(0, 1'b1, 30, at);
        chk("s6 held press flip edge", at, exp_flip(0));
        pop_expect("s6 press", 0, 0, 5, at);
        btn[0] = 1'b0;
        wait_level(0, 1'b0, 30, at);
        pop_expect("s6 release", 0, 1, 5, at);
        chk("s6 drained", int'(valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
